// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Field names match the original hazard_ctrl port list.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_id_vld;
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_rs1_use;
    logic             i_id_rs2_use;
    logic [4:0]       i_id_rd;
    logic             i_id_rd_wren;
    logic             i_id_is_load;
    logic             i_id_is_mem;
    logic             i_ex_redirect;
    logic             i_lsu_ready;

    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_en;
    logic             o_idex_flush;
    logic             o_exmem_en;
    logic             o_memwb_flush;
    logic [1:0]       o_fwd_a_sel;
    logic [1:0]       o_fwd_b_sel;
    logic [CNT_W-1:0] o_stall_cnt;
    logic             o_mem_timeout;

    modport master (
        output i_id_vld, i_id_rs1, i_id_rs2, i_id_rs1_use, i_id_rs2_use,
               i_id_rd, i_id_rd_wren, i_id_is_load, i_id_is_mem,
               i_ex_redirect, i_lsu_ready,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
               o_exmem_en, o_memwb_flush, o_fwd_a_sel, o_fwd_b_sel,
               o_stall_cnt, o_mem_timeout
    );

    modport slave (
        input  i_id_vld, i_id_rs1, i_id_rs2, i_id_rs1_use, i_id_rs2_use,
               i_id_rd, i_id_rd_wren, i_id_is_load, i_id_is_mem,
               i_ex_redirect, i_lsu_ready,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
               o_exmem_en, o_memwb_flush, o_fwd_a_sel, o_fwd_b_sel,
               o_stall_cnt, o_mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: stage enables/flushes,
// registered forwarding selects, stall-cycle counter and LSU timeout flag.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wren;
        logic       load;
        logic       mem;
    } shadow_t;

    typedef enum logic {
        ST_RUN,
        ST_MWAIT
    } state_t;

    state_t            r_state;
    shadow_t           r_ex;
    shadow_t           r_mem;
    shadow_t           r_wb;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    logic              w_freeze;
    logic              w_redirect;
    logic              w_load_use;
    logic              w_bubble;
    shadow_t           w_id;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_pc_en;
    logic              w_ifid_en;
    logic              w_ifid_flush;
    logic              w_idex_en;
    logic              w_idex_flush;
    logic              w_exmem_en;
    logic              w_memwb_flush;
    logic              w_unused;

    function automatic logic f_match(input logic use_i, input logic [4:0] rs,
                                     input shadow_t s);
        return use_i && s.vld && s.wren && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

    // Youngest producer wins; the WB producer is covered by the write-through regfile.
    function automatic logic [1:0] f_fwd(input logic use_i, input logic [4:0] rs,
                                         input shadow_t ex, input shadow_t mem);
        if (f_match(use_i, rs, ex))
            return 2'b01;
        else if (f_match(use_i, rs, mem))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_freeze   = r_mem.vld && r_mem.mem && !bus.i_lsu_ready;
        w_redirect = !w_freeze && bus.i_ex_redirect;
        w_load_use = !w_freeze && !w_redirect && bus.i_id_vld && r_ex.load &&
                     (f_match(bus.i_id_rs1_use, bus.i_id_rs1, r_ex) ||
                      f_match(bus.i_id_rs2_use, bus.i_id_rs2, r_ex));
        w_bubble   = w_redirect || w_load_use;

        w_id = '0;
        if (bus.i_id_vld)
            w_id = {1'b1, bus.i_id_rd, bus.i_id_rd_wren, bus.i_id_is_load, bus.i_id_is_mem};

        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (bus.i_id_vld) begin
            w_fwd_a = f_fwd(bus.i_id_rs1_use, bus.i_id_rs1, r_ex, r_mem);
            w_fwd_b = f_fwd(bus.i_id_rs2_use, bus.i_id_rs2, r_ex, r_mem);
        end

        if (r_state == ST_RUN)
            w_wait_nxt = WAIT_W'(1);
        else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT))
            w_wait_nxt = r_wait_cnt;
        else
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end

    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_en     = 1'b0;
        w_idex_flush  = 1'b1;
        w_exmem_en    = 1'b0;
        w_memwb_flush = 1'b1;
        if (i_reset_n) begin
            w_pc_en       = !w_freeze && !w_load_use;
            w_ifid_en     = !w_freeze && !w_load_use;
            w_ifid_flush  = w_redirect;
            w_idex_en     = !w_freeze;
            w_idex_flush  = w_bubble;
            w_exmem_en    = !w_freeze;
            w_memwb_flush = w_freeze;
        end
    end

    // A redirect arriving during a freeze is not stored: EX is frozen and keeps asserting it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= ST_RUN;
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_fwd_a       <= 2'b00;
            r_fwd_b       <= 2'b00;
            r_stall_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            if (w_freeze) begin
                r_state    <= ST_MWAIT;
                r_wait_cnt <= w_wait_nxt;
                if (w_wait_nxt == WAIT_W'(MEM_TIMEOUT))
                    r_mem_timeout <= 1'b1;
            end else begin
                r_state    <= ST_RUN;
                r_wait_cnt <= '0;
                r_wb       <= r_mem;
                r_mem      <= r_ex;
                r_ex       <= w_bubble ? shadow_t'('0) : w_id;
                r_fwd_a    <= w_bubble ? 2'b00 : w_fwd_a;
                r_fwd_b    <= w_bubble ? 2'b00 : w_fwd_b;
            end
        end
    end

    assign bus.o_pc_en       = w_pc_en;
    assign bus.o_ifid_en     = w_ifid_en;
    assign bus.o_ifid_flush  = w_ifid_flush;
    assign bus.o_idex_en     = w_idex_en;
    assign bus.o_idex_flush  = w_idex_flush;
    assign bus.o_exmem_en    = w_exmem_en;
    assign bus.o_memwb_flush = w_memwb_flush;
    assign bus.o_fwd_a_sel   = r_fwd_a;
    assign bus.o_fwd_b_sel   = r_fwd_b;
    assign bus.o_stall_cnt   = r_stall_cnt;
    assign bus.o_mem_timeout = r_mem_timeout;

    // WB shadow is tracked for completeness; no decision currently depends on it.
    assign w_unused = ^{r_wb, r_mem.load};
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a stage-list model.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       mem;
    } insn_t;

    localparam insn_t BUB = '0;

    logic i_clk = 1'b0;
    logic i_reset_n;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    // Model: pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB.
    insn_t      pipe[$];
    logic [1:0] m_fa;
    logic [1:0] m_fb;
    int         m_stall;
    logic       m_tmo;
    int         m_run;
    logic       m_known;

    function automatic insn_t alu(input int rd, input int rs1, input int rs2);
        insn_t t = '0;
        t.vld = 1'b1; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.u1 = 1'b1; t.u2 = 1'b1; t.wr = 1'b1;
        return t;
    endfunction

    function automatic insn_t lw(input int rd, input int rs1);
        insn_t t = '0;
        t.vld = 1'b1; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.u1 = 1'b1;
        t.wr = 1'b1; t.ld = 1'b1; t.mem = 1'b1;
        return t;
    endfunction

    function automatic insn_t sw(input int rs1, input int rs2);
        insn_t t = '0;
        t.vld = 1'b1; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.u1 = 1'b1; t.u2 = 1'b1; t.mem = 1'b1;
        return t;
    endfunction

    function automatic logic writes(input insn_t p, input logic use_i, input logic [4:0] rs);
        return use_i && p.vld && p.wr && (p.rd != 5'd0) && (p.rd == rs);
    endfunction

    // Distance to the nearest older producer: 1 stage ahead -> 01, 2 stages -> 10.
    function automatic logic [1:0] dist_sel(input logic use_i, input logic [4:0] rs);
        for (int d = 0; d < 2; d++)
            if (writes(pipe[d], use_i, rs))
                return 2'(d + 1);
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input insn_t ins, input logic redir, input logic rdy, input logic rst_n);
        logic frz, rdr, lu;
        logic e_pc, e_ifid, e_ifid_fl, e_idex, e_idex_fl, e_exmem, e_memwb_fl;
        i_reset_n          = rst_n;
        bus.i_id_vld       = ins.vld;
        bus.i_id_rs1       = ins.rs1;
        bus.i_id_rs2       = ins.rs2;
        bus.i_id_rs1_use   = ins.u1;
        bus.i_id_rs2_use   = ins.u2;
        bus.i_id_rd        = ins.rd;
        bus.i_id_rd_wren   = ins.wr;
        bus.i_id_is_load   = ins.ld;
        bus.i_id_is_mem    = ins.mem;
        bus.i_ex_redirect  = redir;
        bus.i_lsu_ready    = rdy;

        frz = pipe[1].vld && pipe[1].mem && !rdy;
        rdr = !frz && redir;
        lu  = !frz && !rdr && ins.vld && pipe[0].ld &&
              (writes(pipe[0], ins.u1, ins.rs1) || writes(pipe[0], ins.u2, ins.rs2));
        if (!rst_n) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            {e_ifid_fl, e_idex_fl, e_memwb_fl} = 3'b111;
        end else begin
            e_pc       = !frz && !lu;
            e_ifid     = !frz && !lu;
            e_ifid_fl  = rdr;
            e_idex     = !frz;
            e_idex_fl  = rdr || lu;
            e_exmem    = !frz;
            e_memwb_fl = frz;
        end

        @(negedge i_clk);
        chk("pc_en",       32'(bus.o_pc_en),       32'(e_pc));
        chk("ifid_en",     32'(bus.o_ifid_en),     32'(e_ifid));
        chk("ifid_flush",  32'(bus.o_ifid_flush),  32'(e_ifid_fl));
        chk("idex_en",     32'(bus.o_idex_en),     32'(e_idex));
        chk("idex_flush",  32'(bus.o_idex_flush),  32'(e_idex_fl));
        chk("exmem_en",    32'(bus.o_exmem_en),    32'(e_exmem));
        chk("memwb_flush", 32'(bus.o_memwb_flush), 32'(e_memwb_fl));
        if (m_known) begin
            chk("fwd_a",       32'(bus.o_fwd_a_sel),   32'(m_fa));
            chk("fwd_b",       32'(bus.o_fwd_b_sel),   32'(m_fb));
            chk("stall_cnt",   32'(bus.o_stall_cnt),   32'(m_stall));
            chk("mem_timeout", 32'(bus.o_mem_timeout), 32'(m_tmo));
        end

        @(posedge i_clk);
        if (!rst_n) begin
            pipe = {BUB, BUB, BUB};
            m_fa = 2'b00; m_fb = 2'b00;
            m_stall = 0; m_tmo = 1'b0; m_run = 0; m_known = 1'b1;
        end else begin
            if (!e_pc && m_stall < (1 << CNT_W) - 1)
                m_stall++;
            if (frz) begin
                m_run++;
                if (m_run >= TMO)
                    m_tmo = 1'b1;
            end else begin
                m_run = 0;
                if (rdr || lu || !ins.vld) begin
                    m_fa = 2'b00; m_fb = 2'b00;
                    pipe.push_front(BUB);
                end else begin
                    m_fa = dist_sel(ins.u1, ins.rs1);
                    m_fb = dist_sel(ins.u2, ins.rs2);
                    pipe.push_front(ins);
                end
                void'(pipe.pop_back());
            end
        end
        #1;
    endtask

    initial begin
        insn_t nop;
        insn_t r;
        nop     = alu(0, 0, 0);
        pipe    = {BUB, BUB, BUB};
        m_known = 1'b0;
        m_fa = 2'b00; m_fb = 2'b00; m_stall = 0; m_tmo = 1'b0; m_run = 0;

        // Reset held three cycles, then first RUN cycle.
        repeat (3) cyc(BUB, 1'b0, 1'b1, 1'b0);
        cyc(BUB, 1'b0, 1'b1, 1'b1);

        // Back-to-back ALU dependency, then with one nop between.
        cyc(alu(5, 1, 2), 1'b0, 1'b1, 1'b1);
        cyc(alu(6, 5, 5), 1'b0, 1'b1, 1'b1);
        chk("alu_b2b_fwd_a", 32'(bus.o_fwd_a_sel), 32'd1);
        chk("alu_b2b_fwd_b", 32'(bus.o_fwd_b_sel), 32'd1);
        cyc(alu(5, 1, 2), 1'b0, 1'b1, 1'b1);
        cyc(nop,          1'b0, 1'b1, 1'b1);
        cyc(alu(6, 5, 5), 1'b0, 1'b1, 1'b1);
        chk("alu_gap_fwd_a", 32'(bus.o_fwd_a_sel), 32'd2);
        chk("alu_gap_fwd_b", 32'(bus.o_fwd_b_sel), 32'd2);

        // Load-use: one bubble, then MEM forwarding.
        cyc(lw(7, 1),     1'b0, 1'b1, 1'b1);
        cyc(alu(8, 7, 1), 1'b0, 1'b1, 1'b1);
        chk("lu_stall_cnt", 32'(bus.o_stall_cnt), 32'd1);
        cyc(alu(8, 7, 1), 1'b0, 1'b1, 1'b1);
        chk("lu_fwd_a", 32'(bus.o_fwd_a_sel), 32'd2);
        chk("lu_fwd_b", 32'(bus.o_fwd_b_sel), 32'd0);
        cyc(lw(0, 1),     1'b0, 1'b1, 1'b1);
        cyc(alu(8, 0, 1), 1'b0, 1'b1, 1'b1);
        chk("x0_no_stall", 32'(bus.o_stall_cnt), 32'd1);

        // Redirect, and redirect coinciding with a load-use hazard.
        cyc(alu(9, 1, 2),   1'b0, 1'b1, 1'b1);
        cyc(alu(10, 9, 9),  1'b1, 1'b1, 1'b1);
        chk("redir_fwd_a", 32'(bus.o_fwd_a_sel), 32'd0);
        cyc(lw(11, 1),      1'b0, 1'b1, 1'b1);
        cyc(alu(12, 11, 0), 1'b1, 1'b1, 1'b1);
        chk("redir_lu_no_stall", 32'(bus.o_stall_cnt), 32'd1);

        // Store waits four cycles in MEM; redirect raised mid-wait.
        cyc(sw(1, 2), 1'b0, 1'b1, 1'b1);
        cyc(nop,      1'b0, 1'b1, 1'b1);
        cyc(nop,      1'b0, 1'b0, 1'b1);
        cyc(nop,      1'b0, 1'b0, 1'b1);
        cyc(nop,      1'b1, 1'b0, 1'b1);
        cyc(nop,      1'b1, 1'b0, 1'b1);
        chk("wait_stall_cnt", 32'(bus.o_stall_cnt), 32'd5);
        cyc(nop,      1'b1, 1'b1, 1'b1);
        cyc(nop,      1'b0, 1'b1, 1'b1);

        // LSU timeout after eight consecutive wait cycles; stall counter saturates.
        cyc(sw(2, 3), 1'b0, 1'b1, 1'b1);
        cyc(nop,      1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cyc(nop, 1'b0, 1'b0, 1'b1);
            if (i == 7) chk("tmo_before", 32'(bus.o_mem_timeout), 32'd0);
            if (i == 8) chk("tmo_at_8",   32'(bus.o_mem_timeout), 32'd1);
        end
        cyc(nop, 1'b0, 1'b1, 1'b1);
        cyc(nop, 1'b0, 1'b1, 1'b1);
        chk("tmo_sticky", 32'(bus.o_mem_timeout), 32'd1);
        chk("stall_sat",  32'(bus.o_stall_cnt),   32'd15);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: r = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: r = lw($urandom_range(0, 3), $urandom_range(0, 3));
                2: r = sw($urandom_range(0, 3), $urandom_range(0, 3));
                default: begin
                    r = insn_t'($urandom);
                    r.vld = 1'b0;
                end
            endcase
            cyc(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) != 0));
        end

        // Reset clears the sticky flag and counter.
        cyc(BUB, 1'b0, 1'b1, 1'b0);
        cyc(BUB, 1'b0, 1'b1, 1'b0);
        chk("rst_tmo_clear",   32'(bus.o_mem_timeout), 32'd0);
        chk("rst_stall_clear", 32'(bus.o_stall_cnt),   32'd0);
        cyc(BUB, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
